// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: opcodes, ALU operation codes, one-hot type
// bit positions, immediate formats and the skid-buffer state encoding.
package decode_pkg;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    // alu_op is {funct3, alt}; these are the fixed codes for non-ALU opcodes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam int T_R = 5;
    localparam int T_I = 4;
    localparam int T_S = 3;
    localparam int T_B = 2;
    localparam int T_U = 1;
    localparam int T_J = 0;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [5:0] typ;
        logic [3:0] alu_op;
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       rd_we;
        logic       mext;
        logic       illegal;
    } dec_t;

    function automatic logic [5:0] fmt_onehot(input fmt_t fmt);
        logic [5:0] t;
        t = '0;
        case (fmt)
            FMT_R:   t[T_R] = 1'b1;
            FMT_I:   t[T_I] = 1'b1;
            FMT_S:   t[T_S] = 1'b1;
            FMT_B:   t[T_B] = 1'b1;
            FMT_U:   t[T_U] = 1'b1;
            FMT_J:   t[T_J] = 1'b1;
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles the format-specific immediate and sign-extends it to XLEN.
// Opcode bits are not needed here, so only instr[31:7] is taken.
module decode_stage_imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  fmt_t            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // fill everything with the sign, then overlay the low word
        imm        = {XLEN{imm32[31]}};
        imm[31:0]  = imm32;
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage with a 2-entry skid buffer, flush and illegal flagging.
// Define DECODE_MEXT_EN to accept M-extension (funct7=0000001) encodings on OP.
//
// state      | meaning
// SKID_EMPTY | no buffered bundle, out_valid=0
// SKID_ONE   | one bundle at the output head
// SKID_TWO   | head plus one skid entry, in_ready=0
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [5:0]      out_type,
    output logic [3:0]      out_alu_op,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic            out_mext,
    output logic            out_illegal
);

`ifdef DECODE_MEXT_EN
    localparam bit MEXT_EN = 1'b1;
`else
    localparam bit MEXT_EN = 1'b0;
`endif

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    fmt_t            fmt;
    logic [3:0]      alu;
    logic            mext;
    dec_t            dec_in;
    logic [XLEN-1:0] imm_in;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    always_comb begin
        fmt  = FMT_NONE;
        alu  = ALU_ADD;
        mext = 1'b0;
        case (opcode)
            OP_OP: begin
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    fmt = FMT_R;
                    alu = {f3, f7[5]};
                end else if (MEXT_EN && f7 == 7'b0000001) begin
                    fmt  = FMT_R;
                    alu  = {f3, 1'b0};
                    mext = 1'b1;
                end
            end
            OP_IMM: begin
                fmt = FMT_I;
                alu = {f3, (f3 == 3'b101) & in_instr[30]};
            end
            OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:         fmt = FMT_S;
            OP_BRANCH: begin
                fmt = FMT_B;
                alu = ALU_SUB;
            end
            OP_LUI: begin
                fmt = FMT_U;
                alu = ALU_PASSB;
            end
            OP_AUIPC:         fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            default:          fmt = FMT_NONE;
        endcase

        dec_in         = '0;
        dec_in.typ     = fmt_onehot(fmt);
        dec_in.alu_op  = alu;
        dec_in.opcode  = opcode;
        dec_in.rd      = in_instr[11:7];
        dec_in.rs1     = in_instr[19:15];
        dec_in.rs2     = in_instr[24:20];
        dec_in.funct3  = f3;
        dec_in.rd_we   = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
                         && (in_instr[11:7] != 5'd0);
        dec_in.mext    = mext;
        dec_in.illegal = (fmt == FMT_NONE);
    end

    decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm_in)
    );

    skid_state_t     state;
    dec_t            ent0, ent1;
    logic [XLEN-1:0] pc0, pc1, imm0, imm1;
    logic            accept, drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SKID_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            ent0      <= '0;
            ent1      <= '0;
            pc0       <= '0;
            pc1       <= '0;
            imm0      <= '0;
            imm1      <= '0;
        end else if (flush) begin
            state     <= SKID_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        ent0      <= dec_in;
                        pc0       <= in_pc;
                        imm0      <= imm_in;
                        out_valid <= 1'b1;
                        state     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && drain) begin
                        ent0 <= dec_in;
                        pc0  <= in_pc;
                        imm0 <= imm_in;
                    end else if (accept) begin
                        ent1     <= dec_in;
                        pc1      <= in_pc;
                        imm1     <= imm_in;
                        in_ready <= 1'b0;
                        state    <= SKID_TWO;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only the head can move
                    if (drain) begin
                        ent0     <= ent1;
                        pc0      <= pc1;
                        imm0     <= imm1;
                        in_ready <= 1'b1;
                        state    <= SKID_ONE;
                    end
                end
                default: begin
                    state     <= SKID_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_pc      = pc0;
    assign out_imm     = imm0;
    assign out_type    = ent0.typ;
    assign out_alu_op  = ent0.alu_op;
    assign out_opcode  = ent0.opcode;
    assign out_rd      = ent0.rd;
    assign out_rs1     = ent0.rs1;
    assign out_rs2     = ent0.rs2;
    assign out_funct3  = ent0.funct3;
    assign out_rd_we   = ent0.rd_we;
    assign out_mext    = ent0.mext;
    assign out_illegal = ent0.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: queue-based reference model checked every cycle, directed
// cases with literal expectations, randomized traffic, and an XLEN=64 instance.
module tb_decode_stage;

`ifdef DECODE_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [5:0]  out_type;
    logic [3:0]  out_alu_op;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_rd_we, out_mext, out_illegal;

    logic        rst_w, flush_w, in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [31:0] in_instr_w;
    logic [63:0] in_pc_w, out_pc_w, out_imm_w;
    logic [5:0]  out_type_w;
    logic [3:0]  out_alu_op_w;
    logic [6:0]  out_opcode_w;
    logic [4:0]  out_rd_w, out_rs1_w, out_rs2_w;
    logic [2:0]  out_funct3_w;
    logic        out_rd_we_w, out_mext_w, out_illegal_w;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_type(out_type), .out_alu_op(out_alu_op), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_imm(out_imm), .out_rd_we(out_rd_we), .out_mext(out_mext), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(64)) dut_w (
        .clk(clk), .rst(rst_w), .flush(flush_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_instr(in_instr_w), .in_pc(in_pc_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_pc(out_pc_w), .out_type(out_type_w), .out_alu_op(out_alu_op_w),
        .out_opcode(out_opcode_w), .out_rd(out_rd_w), .out_rs1(out_rs1_w), .out_rs2(out_rs2_w),
        .out_funct3(out_funct3_w), .out_imm(out_imm_w), .out_rd_we(out_rd_we_w),
        .out_mext(out_mext_w), .out_illegal(out_illegal_w)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [5:0]  typ;
        logic [3:0]  alu;
        logic        rd_we;
        logic        mext;
        logic        ill;
    } exp_t;

    // Reference decode straight from the ISA rules; immediates via signed shifts.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
        exp_t        e;
        longint      s;
        logic [2:0]  f3;
        logic [6:0]  f7;
        s  = longint'($signed(ins));
        f3 = ins[14:12];
        f7 = ins[31:25];
        e.ins = ins; e.pc = pc; e.imm = '0; e.typ = '0; e.alu = '0; e.mext = 1'b0;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    e.typ = 6'b100000; e.alu = {f3, f7[5]};
                end else if (MEXT && f7 == 7'h01) begin
                    e.typ = 6'b100000; e.alu = {f3, 1'b0}; e.mext = 1'b1;
                end
            end
            7'h13: begin
                e.typ = 6'b010000; e.imm = s >>> 20;
                e.alu = {f3, (f3 == 3'd5) ? ins[30] : 1'b0};
            end
            7'h03, 7'h67: begin e.typ = 6'b010000; e.imm = s >>> 20; end
            7'h23: begin
                e.typ = 6'b001000;
                e.imm = ((s >>> 25) << 5) | 64'(ins[11:7]);
            end
            7'h63: begin
                e.typ = 6'b000100; e.alu = 4'b0001;
                e.imm = ((s >>> 31) << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                        | (64'(ins[11:8]) << 1);
            end
            7'h37: begin e.typ = 6'b000010; e.alu = 4'b1111; e.imm = (s >>> 12) << 12; end
            7'h17: begin e.typ = 6'b000010; e.imm = (s >>> 12) << 12; end
            7'h6f: begin
                e.typ = 6'b000001;
                e.imm = ((s >>> 31) << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                        | (64'(ins[30:21]) << 1);
            end
            default: ;
        endcase
        e.ill   = (e.typ == 6'b0);
        e.rd_we = (e.typ[5] | e.typ[4] | e.typ[1] | e.typ[0]) && (ins[11:7] != 5'd0);
        return e;
    endfunction

    exp_t q[$];
    bit   rdy_en = 1'b0;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            q.delete();
            rdy_en = 1'b0;
        end else if (flush) begin
            q.delete();
            rdy_en = 1'b1;
        end else begin
            acc = in_valid && rdy_en && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(model(in_instr, {32'b0, in_pc}));
            rdy_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
        chk("in_ready", {63'b0, in_ready}, {63'b0, rdy_en && q.size() < 2});
        if (q.size() > 0) begin
            e = q[0];
            chk("bundle", {out_type, out_alu_op, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
                           out_rd_we, out_mext, out_illegal},
                {e.typ, e.alu, e.ins[6:0], e.ins[11:7], e.ins[19:15], e.ins[24:20], e.ins[14:12],
                 e.rd_we, e.mext, e.ill});
            chk("out_pc", {32'b0, out_pc}, {32'b0, e.pc[31:0]});
            chk("out_imm", {32'b0, out_imm}, {32'b0, e.imm[31:0]});
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
        int          k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = ops[k];
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        rst_w = 1'b1; flush_w = 1'b0; in_valid_w = 1'b0; in_instr_w = '0; in_pc_w = '0;
        out_ready_w = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_payload", {out_pc, out_imm}, 64'd0);
        chk("rst_fields", {out_type, out_rd, out_alu_op, out_illegal}, 64'd0);
        rst = 1'b0; rst_w = 1'b0;
        step();
        chk("in_ready_after_rst", {63'b0, in_ready}, 64'd1);

        // addi x1,x2,-5
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        chk("addi_valid", {63'b0, out_valid}, 64'd1);
        chk("addi_type", {58'b0, out_type}, 64'b010000);
        chk("addi_rd_rs1", {54'b0, out_rd, out_rs1}, {54'b0, 5'd1, 5'd2});
        chk("addi_imm", {32'b0, out_imm}, 64'hFFFFFFFB);
        chk("addi_alu_we", {59'b0, out_alu_op, out_rd_we}, {59'b0, 4'b0000, 1'b1});
        step();

        // beq x0,x0,-4
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h104;
        step();
        in_valid = 1'b0;
        chk("beq_type", {58'b0, out_type}, 64'b000100);
        chk("beq_imm", {32'b0, out_imm}, 64'hFFFFFFFC);
        chk("beq_alu_we", {59'b0, out_alu_op, out_rd_we}, {59'b0, 4'b0001, 1'b0});
        step();

        // back-to-back into a stalled output
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500193; in_pc = 32'h200;
        step();
        in_instr = 32'h00A00213; in_pc = 32'h204;
        step();
        chk("skid_full_ready", {63'b0, in_ready}, 64'd0);
        in_instr = 32'h00F00293; in_pc = 32'h208;
        step();
        chk("skid_held_ready", {63'b0, in_ready}, 64'd0);
        chk("skid_head_a", {32'b0, out_pc}, 64'h200);
        out_ready = 1'b1;
        step();
        chk("skid_head_b", {32'b0, out_pc}, 64'h204);
        step();
        in_valid = 1'b0;
        chk("skid_head_c", {32'b0, out_pc}, 64'h208);
        chk("skid_c_valid", {63'b0, out_valid}, 64'd1);
        step();
        chk("skid_drained", {63'b0, out_valid}, 64'd0);

        // flush while full, with a new input presented
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100313; in_pc = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        flush = 1'b1; in_pc = 32'h308;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_ready", {63'b0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_leak", {63'b0, out_valid}, 64'd0);
        end

        // mul x1,x2,x3
        in_valid = 1'b1; in_instr = 32'h023100B3; in_pc = 32'h400;
        step();
        in_valid = 1'b0;
        if (MEXT) begin
            chk("mul_mext_ill", {62'b0, out_mext, out_illegal}, 64'b10);
            chk("mul_type", {58'b0, out_type}, 64'b100000);
        end else begin
            chk("mul_ill", {63'b0, out_illegal}, 64'd1);
            chk("mul_type_we", {57'b0, out_type, out_rd_we}, 64'd0);
        end
        step();

        // reset while full
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500193; in_pc = 32'h500;
        step();
        in_pc = 32'h504;
        step();
        chk("pre_rst_full", {63'b0, in_ready}, 64'd0);
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_mid_pc", {32'b0, out_pc}, 64'd0);
        step();

        // XLEN=64 instance
        chk("w_ready", {63'b0, in_ready_w}, 64'd1);
        in_valid_w = 1'b1; in_instr_w = 32'h123452B7; in_pc_w = 64'hFFFF_FFFF_0000_1000;
        step();
        e = model(in_instr_w, in_pc_w);
        chk("w_lui_imm", out_imm_w, 64'h0000_0000_1234_5000);
        chk("w_lui_alu", {60'b0, out_alu_op_w}, 64'b1111);
        chk("w_lui_valid", {63'b0, out_valid_w}, 64'd1);
        chk("w_lui_pc", out_pc_w, 64'hFFFF_FFFF_0000_1000);
        chk("w_lui_bundle", {out_type_w, out_opcode_w, out_rd_w, out_rs1_w, out_rs2_w,
                             out_funct3_w, out_rd_we_w, out_mext_w, out_illegal_w},
            {e.typ, e.ins[6:0], e.ins[11:7], e.ins[19:15], e.ins[24:20], e.ins[14:12],
             e.rd_we, e.mext, e.ill});
        in_instr_w = 32'h0000_0000;
        step();
        in_valid_w = 1'b0;
        chk("w_zero_ill", {63'b0, out_illegal_w}, 64'd1);
        chk("w_zero_type", {58'b0, out_type_w}, 64'd0);
        in_valid_w = 1'b1; in_instr_w = 32'h8000_006F; in_pc_w = 64'h40;
        step();
        in_valid_w = 1'b0;
        chk("w_jal_imm", out_imm_w, 64'hFFFF_FFFF_FFF0_0000);
        step();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 299) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
